// File: rtl/dc_lum_diff_encoder.sv
// JPEG DC luminance difference encoder: predictor, category/extra bits, LUT sequencing, symbol packing.
// Optional DC_BITCNT_EN adds a running bit_count of emitted symbol lengths, cleared at scan start.
module dc_lum_diff_encoder #(
  parameter int COEFF_W = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dc_valid,
  output logic                      dc_ready,
  input  logic signed [COEFF_W-1:0] dc_coeff,
  input  logic                      scan_start,
  output logic [3:0]                huff_extra_bits,
  input  logic [15:0]               huff_code,
  input  logic [4:0]                huff_length,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [19:0]               out_bits,
  output logic [4:0]                out_len
`ifdef DC_BITCNT_EN
  ,
  output logic [31:0]               bit_count
`endif
);

  // state  | meaning
  // IDLE   | waiting for a DC coefficient, dc_ready high
  // LOOKUP | category on huff_extra_bits, LUT result sampled into output regs
  // OUT    | symbol presented, waiting for out_ready
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] OUT    = 2'd2;

  localparam logic signed [COEFF_W:0] DIFF_MAX = $signed({2'b00, {(COEFF_W-1){1'b1}}});
  localparam logic signed [COEFF_W:0] DIFF_MIN = -DIFF_MAX;
  localparam logic signed [COEFF_W:0] ONE      = $signed({{COEFF_W{1'b0}}, 1'b1});

  logic [1:0]                state;
  logic signed [COEFF_W-1:0] predictor;
  logic [COEFF_W:0]          extra_q;

  logic signed [COEFF_W-1:0] pred_sel;
  logic signed [COEFF_W:0]   diff_full;
  logic signed [COEFF_W:0]   diff_clamp;
  logic [COEFF_W:0]          mag;
  logic [COEFF_W:0]          ext_src;
  logic [COEFF_W:0]          mask;
  logic [3:0]                cat_next;
  logic [COEFF_W:0]          extra_next;
  logic [19:0]               code_shift;
  logic                      accept;

  assign accept = dc_valid && dc_ready;

  always_comb begin
    pred_sel   = scan_start ? '0 : predictor;
    diff_full  = {dc_coeff[COEFF_W-1], dc_coeff} - {pred_sel[COEFF_W-1], pred_sel};
    if (diff_full > DIFF_MAX)
      diff_clamp = DIFF_MAX;
    else if (diff_full < DIFF_MIN)
      diff_clamp = DIFF_MIN;
    else
      diff_clamp = diff_full;
    mag      = diff_clamp[COEFF_W] ? -diff_clamp : diff_clamp;
    cat_next = 4'd0;
    for (int i = 0; i <= COEFF_W; i++)
      if (mag[i]) cat_next = 4'(i + 1);
    // negative differences carry the ones' complement of the magnitude
    ext_src    = diff_clamp[COEFF_W] ? diff_clamp - ONE : diff_clamp;
    mask       = ({{COEFF_W{1'b0}}, 1'b1} << cat_next) - {{COEFF_W{1'b0}}, 1'b1};
    extra_next = ext_src & mask;
    code_shift = {4'b0000, huff_code} << huff_extra_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      predictor       <= '0;
      extra_q         <= '0;
      dc_ready        <= 1'b1;
      huff_extra_bits <= 4'd0;
      out_valid       <= 1'b0;
      out_bits        <= 20'd0;
      out_len         <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state           <= LOOKUP;
            dc_ready        <= 1'b0;
            predictor       <= dc_coeff;
            huff_extra_bits <= cat_next;
            extra_q         <= extra_next;
          end
        end
        LOOKUP: begin
          out_bits  <= code_shift | {{(19-COEFF_W){1'b0}}, extra_q};
          out_len   <= huff_length + {1'b0, huff_extra_bits};
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            dc_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          dc_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DC_BITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_count <= 32'd0;
    else if (accept && scan_start)
      bit_count <= 32'd0;
    else if (out_valid && out_ready)
      bit_count <= bit_count + {27'd0, out_len};
  end
`endif

endmodule
